multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM that sequences the multi-cycle MIPS Data_Path: decodes OP/Funct from the IR
//  and drives every datapath control strobe per cycle. Supports R-type (add/sub/and/or/slt),
//  lw, sw, addi and beq. Sits beside Data_Path and replaces hand-driven control in benches.
// PARAMETERS
//  SUPPORT_BEQ   1  0: opcode 0x04 treated as illegal
//  SUPPORT_ADDI  1  0: opcode 0x08 treated as illegal
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  reset         in   1  synchronous, active-high
//  enable_i      in   1  0: FSM holds state, all write strobes forced 0
//  OP            in   6  IR[31:26] from Data_Path
//  Funct         in   6  IR[5:0] from Data_Path
//  Zero          in   1  ALU zero flag, used in BRANCH only
//  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc  out 1 each
//  ALUSrcB       out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALUControl    out  4  AND 0000, OR 0001, ADD 0100, SUB 0101, SLT 0111
//  instr_done_o  out  1  one-cycle pulse in final state of each instruction
//  illegal_o     out  1  one-cycle pulse in DECODE on unsupported OP/Funct
//  state_o       out  4  current state encoding (debug)
// BEHAVIOUR
//  - reset=1 at edge -> state=FETCH. While reset=1 all outputs 0 except ALUControl=ADD, state_o=FETCH.
//  - Outputs are combinational from registered state (+Zero/Funct where noted); defaults: all 1-bit 0,
//    ALUSrcB=00, ALUControl=ADD. enable_i=0 gates PCWrite/MemWrite/IRWrite/RegWrite and pulses to 0.
//  - States (encoding in pkg) and asserted signals:
//    FETCH    IRWrite, PCWrite, ALUSrcB=01, ADD, PCSrc=0, IorD=0          -> DECODE
//    DECODE   ALUSrcB=11, ADD (branch target into ALUOut)                 -> by OP
//             OP 0x23/0x2B->MEMADR; 0x00 & valid Funct->EXEC_R; 0x08->ADDI_EX;
//             0x04->BRANCH; else illegal_o=1 -> FETCH (no writes)
//    MEMADR   ALUSrcA=1, ALUSrcB=10, ADD       -> MEMREAD (lw) / MEMWRITE (sw)
//    MEMREAD  IorD=1                           -> MEMWB
//    MEMWB    MemtoReg=1, RegDst=0, RegWrite, done -> FETCH
//    MEMWRITE IorD=1, MemWrite, done           -> FETCH
//    EXEC_R   ALUSrcA=1, ALUSrcB=00, ALUControl=alu_decoder(Funct) -> ALUWB
//    ALUWB    RegDst=1, MemtoReg=0, RegWrite, done -> FETCH
//    ADDI_EX  ALUSrcA=1, ALUSrcB=10, ADD       -> ADDI_WB
//    ADDI_WB  RegDst=0, MemtoReg=0, RegWrite, done -> FETCH
//    BRANCH   ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1, PCWrite=Zero, done -> FETCH
//  - Latency FETCH..done inclusive: beq 3, R/sw/addi 4, lw 5 cycles; illegal 2 cycles, no done.
//  - Funct valid set: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; others illegal in DECODE.
//  - OP/Funct sampled only in DECODE/EXEC_R; changes elsewhere ignored.
//  - enable_i=0 mid-instruction: state frozen, resume exactly where stopped on enable_i=1.
//  - reset mid-instruction: abort, no further strobes; next cycle after release is FETCH.
//  - Unreachable state codes -> FETCH next cycle, outputs at defaults.
// STRUCTURE
//  - Package data_path_ctrl_pkg: state localparams, OP codes, Funct codes, ALUControl codes,
//    ALUSrcB select codes; shared with Data_Path benches.
//  - Sub-module alu_decoder: Funct[5:0] -> {ALUControl[3:0], funct_valid}; purely combinational.
//  - Top: state register, next-state logic, output decode, enable/reset gating.
// TESTING
//  - reset=1 two cycles, release -> state_o=FETCH, IRWrite=PCWrite=1 on first cycle, ALUSrcB=01.
//  - OP=0x00 Funct=0x22 -> FETCH,DECODE,EXEC_R(ALUControl=0101),ALUWB(RegDst=1,RegWrite=1), done once.
//  - OP=0x23 -> 5 cycles; MEMREAD IorD=1; MEMWB MemtoReg=1,RegWrite=1; OP=0x2B -> MemWrite=1 exactly 1 cycle.
//  - OP=0x04 with Zero=1 -> BRANCH PCWrite=1,PCSrc=1; repeat Zero=0 -> PCWrite=0, still done pulse.
//  - OP=0x3F and OP=0x00/Funct=0x03 -> illegal_o pulse in DECODE, no RegWrite/MemWrite, back to FETCH.
//  - enable_i=0 for 3 cycles in MEMADR of lw, then reset pulse in MEMREAD -> frozen, then FETCH.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// data_path_ctrl_pkg: shared state, opcode, funct, ALU and ALUSrcB encodings for the multi-cycle MIPS
package data_path_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        ALUWB    = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BRANCH   = 4'd10
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: instruction fields in, datapath control strobes out
interface multicycle_control_unit_if;
    logic       enable_i;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       PCSrc;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic       instr_done_o;
    logic       illegal_o;
    logic [3:0] state_o;
    modport master (
        input  enable_i, OP, Funct, Zero,
        output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc,
               ALUSrcB, ALUControl, instr_done_o, illegal_o, state_o
    );
    modport slave (
        output enable_i, OP, Funct, Zero,
        input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc,
               ALUSrcB, ALUControl, instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// alu_decoder: R-type Funct field to ALU operation code plus a supported-function flag
module alu_decoder
    import data_path_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);
    // unsupported functions fall back to ADD; the FSM never executes them
    always_comb begin
        alu_control = (funct == F_SUB) ? ALU_SUB :
                      (funct == F_AND) ? ALU_AND :
                      (funct == F_OR)  ? ALU_OR  :
                      (funct == F_SLT) ? ALU_SLT : ALU_ADD;
        funct_valid = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT);
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multi-cycle MIPS datapath
module multicycle_control_unit
    import data_path_ctrl_pkg::*;
#(
    parameter bit SUPPORT_BEQ  = 1'b1,
    parameter bit SUPPORT_ADDI = 1'b1
) (
    input logic                       clk,
    input logic                       reset,
    multicycle_control_unit_if.master bus
);
    state_t     state;
    state_t     state_nxt;
    logic       is_lw;
    logic       is_mem;
    logic       is_r;
    logic       is_addi;
    logic       is_beq;
    logic [3:0] r_alu;
    logic       funct_valid;
    logic       pc_w;
    logic       iord;
    logic       mem_w;
    logic       ir_w;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_w;
    logic       src_a;
    logic       pc_src;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic       done;
    logic       illegal;

    alu_decoder u_alu_decoder (
        .funct       (bus.Funct),
        .alu_control (r_alu),
        .funct_valid (funct_valid)
    );

    assign is_mem  = (bus.OP == OP_LW) || (bus.OP == OP_SW);
    assign is_r    = (bus.OP == OP_RTYPE) && funct_valid;
    assign is_addi = SUPPORT_ADDI && (bus.OP == OP_ADDI);
    assign is_beq  = SUPPORT_BEQ && (bus.OP == OP_BEQ);

    // state register; lw/sw choice is latched in DECODE so later OP changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            is_lw <= 1'b0;
        end else if (bus.enable_i) begin
            state <= state_nxt;
            if (state == DECODE) is_lw <= (bus.OP == OP_LW);
        end
    end

    // next state and raw per-state control strobes
    always_comb begin
        state_nxt  = FETCH;
        pc_w       = 1'b0;
        iord       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_w      = 1'b0;
        src_a      = 1'b0;
        pc_src     = 1'b0;
        src_b      = SRCB_REG;
        alu        = ALU_ADD;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                src_b     = SRCB_FOUR;
                state_nxt = DECODE;
            end
            DECODE: begin
                src_b     = SRCB_IMM_SH;
                state_nxt = is_mem ? MEMADR : is_r ? EXEC_R : is_addi ? ADDI_EX : is_beq ? BRANCH : FETCH;
                illegal   = !(is_mem || is_r || is_addi || is_beq);
            end
            MEMADR: begin
                src_a     = 1'b1;
                src_b     = SRCB_IMM;
                state_nxt = is_lw ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                iord      = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_w      = 1'b1;
                done       = 1'b1;
            end
            MEMWRITE: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                done  = 1'b1;
            end
            EXEC_R: begin
                src_a     = 1'b1;
                alu       = r_alu;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_dst = 1'b1;
                reg_w   = 1'b1;
                done    = 1'b1;
            end
            ADDI_EX: begin
                src_a     = 1'b1;
                src_b     = SRCB_IMM;
                state_nxt = ADDI_WB;
            end
            ADDI_WB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
            BRANCH: begin
                src_a  = 1'b1;
                alu    = ALU_SUB;
                pc_src = 1'b1;
                pc_w   = bus.Zero;
                done   = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // reset forces defaults; enable low suppresses every write strobe and pulse
    always_comb begin
        bus.PCWrite      = !reset && bus.enable_i && pc_w;
        bus.MemWrite     = !reset && bus.enable_i && mem_w;
        bus.IRWrite      = !reset && bus.enable_i && ir_w;
        bus.RegWrite     = !reset && bus.enable_i && reg_w;
        bus.instr_done_o = !reset && bus.enable_i && done;
        bus.illegal_o    = !reset && bus.enable_i && illegal;
        bus.IorD         = !reset && iord;
        bus.RegDst       = !reset && reg_dst;
        bus.MemtoReg     = !reset && mem_to_reg;
        bus.ALUSrcA      = !reset && src_a;
        bus.PCSrc        = !reset && pc_src;
        bus.ALUSrcB      = reset ? SRCB_REG : src_b;
        bus.ALUControl   = reset ? ALU_ADD : alu;
        bus.state_o      = reset ? FETCH : state;
    end
endmodule
